// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder: shifts in a serial device ID, waits for slave ready, drives one-hot select and read-mux index.
// Define SPLIT_SUPPORT_EN to add split-transaction parking (SPLIT state, split_req).
module bus_addr_decoder #(
  parameter int NUM_SLAVES = 3,
  parameter int DEV_WIDTH = 4,
  parameter int READY_TIMEOUT = 16,
  localparam int RW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  bus_busy,
  input  logic                  master_valid,
  input  logic                  wr_bus,
  input  logic [NUM_SLAVES-1:0] s_ready,
  input  logic [NUM_SLAVES-1:0] s_split,
  output logic [NUM_SLAVES-1:0] s_sel,
  output logic [RW-1:0]         rd_sel,
  output logic                  ack,
  output logic                  dec_err,
  output logic                  split_req
);
  localparam int CW = $clog2(DEV_WIDTH + 1);
  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam logic [DEV_WIDTH:0] NS = (DEV_WIDTH + 1)'(NUM_SLAVES);
`ifdef SPLIT_SUPPORT_EN
  typedef enum logic [2:0] {IDLE, ADDR, DECODE, CONNECT, WAIT_REL, SPLIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DECODE, CONNECT, WAIT_REL} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DEV_WIDTH-1:0] sh, sh_n, sh_in;
  logic [TW-1:0] tmo, tmo_n;
  logic [NUM_SLAVES-1:0] s_sel_n, hot;
  logic [RW-1:0] rd_sel_n;
  logic ack_n, err_n, id_ok, rdy, parked;
  assign sh_in = DEV_WIDTH'({sh, wr_bus});
  assign id_ok = {1'b0, sh} < NS;
  assign hot = NUM_SLAVES'(1) << sh;
  assign rdy = |(s_ready & hot);
`ifdef SPLIT_SUPPORT_EN
  logic [RW-1:0] park, park_n;
  logic [NUM_SLAVES-1:0] park_hot;
  logic split_n, bb_q;
  assign parked = state == SPLIT;
  assign park_hot = NUM_SLAVES'(1) << park;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      park <= '0;
      split_req <= 1'b0;
      bb_q <= 1'b0;
    end else begin
      park <= park_n;
      split_req <= split_n;
      bb_q <= bus_busy;
    end
`else
  logic unused_split;
  assign unused_split = ^s_split;
  assign parked = 1'b0;
  assign split_req = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    tmo_n = tmo;
    s_sel_n = s_sel;
    rd_sel_n = rd_sel;
    ack_n = 1'b0;
    err_n = 1'b0;
`ifdef SPLIT_SUPPORT_EN
    park_n = park;
    split_n = split_req;
`endif
    if (!bus_busy && !parked) begin
      state_n = IDLE;
      cnt_n = '0;
      sh_n = '0;
      tmo_n = '0;
      s_sel_n = '0;
      rd_sel_n = '0;
    end else begin
      case (state)
        IDLE: if (master_valid) begin
          sh_n = sh_in;
          cnt_n = CW'(1);
          state_n = DEV_WIDTH == 1 ? DECODE : ADDR;
        end
        ADDR: if (master_valid) begin
          sh_n = sh_in;
          cnt_n = cnt + 1'b1;
          state_n = cnt == CW'(DEV_WIDTH - 1) ? DECODE : ADDR;
        end
        DECODE: begin
          // ready is checked before the limit so a last-cycle ready still connects
          if (!id_ok || (!rdy && tmo == TW'(READY_TIMEOUT - 1))) begin
            err_n = 1'b1;
            state_n = WAIT_REL;
          end else if (rdy) begin
            s_sel_n = hot;
            rd_sel_n = sh[RW-1:0];
            ack_n = 1'b1;
            state_n = CONNECT;
          end else tmo_n = tmo + 1'b1;
        end
`ifdef SPLIT_SUPPORT_EN
        CONNECT: if (|(s_split & s_sel)) begin
          s_sel_n = '0;
          rd_sel_n = '0;
          park_n = rd_sel;
          split_n = 1'b1;
          cnt_n = '0;
          sh_n = '0;
          state_n = SPLIT;
        end
        SPLIT: begin
          if (split_req && !(|(s_split & park_hot))) split_n = 1'b0;
          // other masters' frames are only watched for an ID aimed at the parked slave
          if (!split_req && bus_busy && !bb_q) begin
            s_sel_n = park_hot;
            rd_sel_n = park;
            ack_n = 1'b1;
            cnt_n = '0;
            sh_n = '0;
            state_n = CONNECT;
          end else if (!bus_busy) begin
            cnt_n = '0;
            sh_n = '0;
          end else if (master_valid && cnt != CW'(DEV_WIDTH)) begin
            sh_n = sh_in;
            cnt_n = cnt + 1'b1;
            err_n = cnt == CW'(DEV_WIDTH - 1) && sh_in == DEV_WIDTH'(park);
          end
        end
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      tmo <= '0;
      s_sel <= '0;
      rd_sel <= '0;
      ack <= 1'b0;
      dec_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      tmo <= tmo_n;
      s_sel <= s_sel_n;
      rd_sel <= rd_sel_n;
      ack <= ack_n;
      dec_err <= err_n;
    end
endmodule

// File: tb/tb_bus_addr_decoder.sv
// tb_bus_addr_decoder: directed frames with a scoreboard of expected ack/dec_err events.
module tb_bus_addr_decoder;
  logic clk = 1'b0, rstn, bus_busy, master_valid, wr_bus;
  logic [2:0] s_ready, s_split, s_sel;
  logic [1:0] rd_sel;
  logic ack, dec_err, split_req;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {bit is_ack; logic [2:0] sel; logic [1:0] rd; int at;} ev_t;
  ev_t q[$];
  bus_addr_decoder #(.NUM_SLAVES(3), .DEV_WIDTH(4), .READY_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .bus_busy(bus_busy), .master_valid(master_valid), .wr_bus(wr_bus),
    .s_ready(s_ready), .s_split(s_split), .s_sel(s_sel), .rd_sel(rd_sel), .ack(ack),
    .dec_err(dec_err), .split_req(split_req)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
`ifdef SPLIT_SUPPORT_EN
  localparam bit SPLIT_BUILD = 1'b1;
`else
  localparam bit SPLIT_BUILD = 1'b0;
`endif
  always @(negedge clk) if (rstn) begin
    ev_t e;
    checks++;
    if (!$onehot0(s_sel) || (ack && dec_err) || (!SPLIT_BUILD && split_req)) begin
      errors++;
      $display("FAIL exclusivity @%0d: s_sel=%b ack=%b dec_err=%b split_req=%b", cyc, s_sel, ack, dec_err, split_req);
    end
    if (ack || dec_err) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event @%0d: ack=%b dec_err=%b s_sel=%b, none expected", cyc, ack, dec_err, s_sel);
      end else begin
        e = q.pop_front();
        if (e.is_ack !== ack || e.sel !== s_sel || e.rd !== rd_sel || (e.at >= 0 && e.at != cyc)) begin
          errors++;
          $display("FAIL event @%0d: got ack=%b s_sel=%b rd_sel=%0d, expected ack=%b s_sel=%b rd_sel=%0d at %0d",
                   cyc, ack, s_sel, rd_sel, e.is_ack, e.sel, e.rd, e.at);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_ev(input bit a, input logic [2:0] s, input logic [1:0] r, input int at);
    q.push_back('{a, s, r, at});
  endtask
  task automatic frame(input logic [3:0] id, input int gap, input int nbits, output int c);
    for (int i = 3; i > 3 - nbits; i--) begin
      master_valid = 1'b1;
      wr_bus = id[i];
      tick(1);
      master_valid = 1'b0;
      wr_bus = 1'b0;
      if (gap > 0 && i > 4 - nbits) tick(gap);
    end
    c = cyc;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL missing_event @%0d: %0d expected events not seen", cyc, q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic release_bus();
    bus_busy = 1'b0;
    tick(2);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c;
    rstn = 1'b0; bus_busy = 1'b0; master_valid = 1'b0; wr_bus = 1'b0; s_ready = 3'b111; s_split = 3'b000;
    tick(3);
    chk("rst_s_sel", 32'(s_sel), 0);
    chk("rst_rd_sel", 32'(rd_sel), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dec_err", 32'(dec_err), 0);
    chk("rst_split_req", 32'(split_req), 0);
    rstn = 1'b1;
    tick(2);
    bus_busy = 1'b1;
    frame(4'd1, 0, 4, c);
    push_ev(1'b1, 3'b010, 2'd1, c + 1);
    drain();
    chk("hold_s_sel", 32'(s_sel), 32'b010);
    chk("hold_rd_sel", 32'(rd_sel), 1);
    chk("ack_one_cycle", 32'(ack), 0);
    bus_busy = 1'b0;
    tick(1);
    chk("rel_s_sel", 32'(s_sel), 0);
    chk("rel_rd_sel", 32'(rd_sel), 0);
    tick(1);
    bus_busy = 1'b1;
    frame(4'd2, 2, 4, c);
    push_ev(1'b1, 3'b100, 2'd2, c + 1);
    drain();
    chk("stall_s_sel", 32'(s_sel), 32'b100);
    release_bus();
    bus_busy = 1'b1;
    frame(4'd7, 0, 4, c);
    push_ev(1'b0, 3'b000, 2'd0, c + 1);
    drain();
    chk("invalid_s_sel", 32'(s_sel), 0);
    release_bus();
    s_ready = 3'b011;
    bus_busy = 1'b1;
    frame(4'd2, 0, 4, c);
    push_ev(1'b0, 3'b000, 2'd0, c + 16);
    drain();
    chk("timeout_s_sel", 32'(s_sel), 0);
    release_bus();
    bus_busy = 1'b1;
    frame(4'd2, 0, 4, c);
    push_ev(1'b1, 3'b100, 2'd2, c + 16);
    repeat (15) @(posedge clk);
    #1;
    s_ready = 3'b111;
    drain();
    chk("late_ready_s_sel", 32'(s_sel), 32'b100);
    release_bus();
    bus_busy = 1'b1;
    frame(4'b0010, 0, 2, c);
    bus_busy = 1'b0;
    tick(1);
    chk("abort_s_sel", 32'(s_sel), 0);
    tick(1);
    bus_busy = 1'b1;
    frame(4'd0, 0, 4, c);
    push_ev(1'b1, 3'b001, 2'd0, c + 1);
    drain();
    chk("after_abort_s_sel", 32'(s_sel), 32'b001);
    release_bus();
    bus_busy = 1'b1;
    frame(4'd2, 0, 4, c);
    push_ev(1'b1, 3'b100, 2'd2, c + 1);
    drain();
    rstn = 1'b0;
    #1;
    chk("arst_s_sel", 32'(s_sel), 0);
    chk("arst_rd_sel", 32'(rd_sel), 0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    frame(4'd1, 0, 4, c);
    push_ev(1'b1, 3'b010, 2'd1, c + 1);
    drain();
    chk("post_rst_s_sel", 32'(s_sel), 32'b010);
    release_bus();
`ifdef SPLIT_SUPPORT_EN
    bus_busy = 1'b1;
    frame(4'd1, 0, 4, c);
    push_ev(1'b1, 3'b010, 2'd1, c + 1);
    drain();
    s_split = 3'b010;
    tick(1);
    chk("split_s_sel", 32'(s_sel), 0);
    chk("split_req_set", 32'(split_req), 1);
    bus_busy = 1'b0;
    tick(1);
    bus_busy = 1'b1;
    tick(1);
    frame(4'd1, 0, 4, c);
    push_ev(1'b0, 3'b000, 2'd0, -1);
    drain();
    bus_busy = 1'b0;
    s_split = 3'b000;
    tick(1);
    chk("split_req_clr", 32'(split_req), 0);
    tick(1);
    bus_busy = 1'b1;
    tick(1);
    push_ev(1'b1, 3'b010, 2'd1, cyc);
    drain();
    chk("resume_s_sel", 32'(s_sel), 32'b010);
    release_bus();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_addr_decoder.md
# bus_addr_decoder

Serial-bus slave-select controller between the arbiter and the slave ports. It watches the granted master's serial frame, shifts in the device-ID bits and waits for the target slave to be ready. It then drives a one-hot slave select and a read-mux index that steer the bus muxes, and holds the connection until the arbiter releases the bus. Invalid IDs and unresponsive slaves are reported back to the master.

## Interface
Parameters:
- NUM_SLAVES, 3, number of slave ports; legal 1..2**DEV_WIDTH
- DEV_WIDTH, 4, device-ID bits at head of each address frame
- READY_TIMEOUT, 16, max cycles in DECODE waiting for slave ready; ≥1

Ports:
- clk  in  1  bus clock
- rstn  in  1  asynchronous active-low reset
- bus_busy  in  1  arbiter: some master holds grant
- master_valid  in  1  muxed master valid; qualifies wr_bus bit
- wr_bus  in  1  muxed serial master-to-slave data
- s_ready  in  NUM_SLAVES  per-slave slave_ready
- s_split  in  NUM_SLAVES  per-slave split request (used only with SPLIT_EN)
- s_sel  out  NUM_SLAVES  one-hot slave select to bus muxes
- rd_sel  out  $clog2(NUM_SLAVES) (min 1)  index of connected slave for read mux
- ack  out  1  one-cycle pulse: device decoded and connected
- dec_err  out  1  one-cycle pulse: invalid ID or ready timeout
- split_req  out  1  to arbiter: a split transaction is parked (SPLIT_EN only)

## Operation
- Reset values: s_sel=0, rd_sel=0, ack=0, dec_err=0, split_req=0; state IDLE, bit count 0, shift reg 0, timeout counter 0.
- Frame: master sends DEV_WIDTH ID bits MSB-first, one bit per cycle where master_valid=1; cycles with master_valid=0 are stalls (no shift, no count). Master waits for ack before sending the in-device offset and data, which go to the selected slave only.
- States:
  - IDLE: bus_busy && master_valid → shift bit, count=1, ADDR (DEV_WIDTH=1 → DECODE directly).
  - ADDR: shift on each valid bit; when count reaches DEV_WIDTH → DECODE.
  - DECODE: ID ≥ NUM_SLAVES → dec_err pulse, WAIT_REL. s_ready[ID]=1 → s_sel[ID]=1, rd_sel=ID, ack pulse, CONNECT. Otherwise increment timeout; on the READY_TIMEOUT-th DECODE cycle without ready → dec_err, WAIT_REL.
  - CONNECT: hold s_sel/rd_sel; master_valid ignored by decoder.
  - WAIT_REL: outputs idle; wait for bus release.
- bus_busy=0 in any state except SPLIT → IDLE next cycle, s_sel cleared, count/timeout cleared. This covers a master losing grant mid-address.
- ack and dec_err never assert in the same cycle; at most one per frame.
- Only one s_sel bit may ever be high.

## Timing
- Last ID bit sampled at cycle N → DECODE at N+1. With slave ready, ack and s_sel are registered high at N+2; ack is high for exactly that cycle.
- Invalid ID: dec_err high at N+2 for one cycle.
- Timeout: dec_err high READY_TIMEOUT cycles after DECODE entry.
- bus_busy falls at cycle T → s_sel=0 at T+1.
- s_ready rising on the same cycle as the timeout limit: ready wins (connect, no error).

## Configuration
- SPLIT_SUPPORT_EN defined: adds state SPLIT.
  - In CONNECT, s_split[sel]=1 → s_sel cleared, parked index stored, split_req=1, SPLIT. The arbiter may grant other masters; the decoder ignores their frames except ID decode is blocked (a new frame to the parked slave gets dec_err).
  - Parked slave drops s_split → split_req=0. On the next bus_busy rise the decoder re-selects the parked slave without an address phase (ack pulse, CONNECT).
- SPLIT_SUPPORT_EN undefined: s_split ignored, split_req tied 0, no SPLIT state.

## Test plan
- Reset: assert rstn=0 mid-CONNECT → all outputs 0 immediately; after release, a new frame decodes normally.
- Valid decode: ID 4'b0001, s_ready=3'b111 → ack at N+2 for 1 cycle, s_sel=3'b010, rd_sel=1; drop bus_busy → s_sel=0 next cycle.
- Stalled frame: ID 4'b0010 sent with master_valid gaps of 2 cycles between bits → s_sel=3'b100, rd_sel=2, ack once.
- Invalid ID 4'd7 → dec_err single pulse at N+2, s_sel stays 0, no ack.
- Timeout: ID 2, s_ready[2]=0 → dec_err after 16 DECODE cycles. Repeat with s_ready[2] rising on cycle 16 → ack, no dec_err.
- Abort and split: bus_busy drops after 2 of 4 ID bits → IDLE, next full frame ID 0 decodes correctly. With SPLIT_SUPPORT_EN, slave 1 raises s_split in CONNECT → s_sel=0, split_req=1; s_split falls → split_req=0; next grant → s_sel=3'b010 plus ack with no address bits sent.
